// File: rtl/uart_buffered.sv
// uart_buffered: memory-mapped UART with TX/RX FIFOs, sticky status flags and a level RX interrupt.
// Latency: every bus request is answered 1 cycle later; an idle transmitter starts the start bit 2 cycles after a TXDATA write.
// Backpressure: none on the bus; TXDATA writes to a full TX FIFO are dropped (tx_overflow), received bytes hitting a full RX FIFO are dropped (rx_overrun).
// Optional parity bit in both directions is built when UART_PARITY_EN is defined.

// Small synchronous FIFO; the pointers carry an extra wrap bit to tell full from empty.
module uart_buffered_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] head_dat,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop_rdy && !empty;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a simultaneous push.
    assign do_push  = push_vld && (!full || do_pop);
    assign head_dat = mem[rd_ptr[AW-1:0]];

    // Pointer update.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end
endmodule

module uart_buffered #(
    parameter int          CLOCK_FREQUENCY = 50000000,
    parameter int          UART_BAUD_RATE  = 9600,
    parameter logic [31:0] BASE_ADDRESS    = 32'h80000000,
    parameter int          DATA_BITS       = 8,
    parameter int          STOP_BITS       = 1,
    parameter int          FIFO_DEPTH      = 16,
    parameter int          PARITY_ODD      = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] rw_address,
    output logic [31:0] read_data,
    input  logic        read_request,
    output logic        read_response,
    input  logic [7:0]  write_data,
    input  logic        write_request,
    output logic        write_response,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        uart_irq
);
    localparam int            CPB       = CLOCK_FREQUENCY / UART_BAUD_RATE;
    localparam int            CW        = $clog2(CPB);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);
    localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic          PAR_ODD   = (PARITY_ODD != 0);
`ifdef UART_PARITY_EN
    localparam logic          HAS_PARITY = 1'b1;
`else
    localparam logic          HAS_PARITY = 1'b0;
`endif
    localparam logic [31:0]   ADDR_TX   = BASE_ADDRESS;
    localparam logic [31:0]   ADDR_RX   = BASE_ADDRESS + 32'd4;
    localparam logic [31:0]   ADDR_ST   = BASE_ADDRESS + 32'd8;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

    // Bus decode
    logic                 wr_tx;
    logic                 rd_rx;
    logic                 rd_st;
    logic [31:0]          read_data_d;
    logic [7:0]           status_vec;

    // FIFO interfaces
    logic                 tx_push_vld;
    logic                 tx_pop_rdy;
    logic [DATA_BITS-1:0] tx_head_dat;
    logic                 tx_empty;
    logic                 tx_full;
    logic                 rx_push_vld;
    logic [DATA_BITS-1:0] rx_head_dat;
    logic                 rx_empty;
    logic                 rx_full;

    // Sticky flags
    logic                 rx_overrun;
    logic                 frame_error;
    logic                 parity_error;
    logic                 tx_overflow;
    logic                 frame_err_set;
    logic                 parity_err_set;

    // TX FSM state
    tx_state_t            tx_state, tx_state_d;
    logic [CW-1:0]        tx_cnt, tx_cnt_d;
    logic [2:0]           tx_idx, tx_idx_d;
    logic [DATA_BITS-1:0] tx_byte, tx_byte_d;
    logic                 tx_par, tx_par_d;
    logic                 tx_line, tx_line_d;

    // RX FSM state
    logic                 rx_meta;
    logic                 rx_sync;
    rx_state_t            rx_state, rx_state_d;
    logic [CW-1:0]        rx_cnt, rx_cnt_d;
    logic [2:0]           rx_idx, rx_idx_d;
    logic [DATA_BITS-1:0] rx_shift, rx_shift_d;
    logic                 rx_par_bad, rx_par_bad_d;

    assign wr_tx       = write_request && (rw_address == ADDR_TX);
    assign rd_rx       = read_request && (rw_address == ADDR_RX);
    assign rd_st       = read_request && (rw_address == ADDR_ST);
    assign tx_push_vld = wr_tx && !tx_full;
    assign uart_tx     = tx_line;

    assign status_vec = {tx_overflow, parity_error, frame_error, rx_overrun,
                         rx_full, !rx_empty, tx_full, tx_empty && (tx_state == TX_IDLE)};

    uart_buffered_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push_vld (tx_push_vld),
        .push_dat (write_data[DATA_BITS-1:0]),
        .pop_rdy  (tx_pop_rdy),
        .head_dat (tx_head_dat),
        .empty    (tx_empty),
        .full     (tx_full)
    );

    uart_buffered_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push_vld (rx_push_vld),
        .push_dat (rx_shift),
        .pop_rdy  (rd_rx),
        .head_dat (rx_head_dat),
        .empty    (rx_empty),
        .full     (rx_full)
    );

    // Read mux: zero unless a mapped register is read this cycle.
    always_comb begin
        read_data_d = '0;
        if (rd_rx && !rx_empty) read_data_d[DATA_BITS-1:0] = rx_head_dat;
        else if (rd_st)         read_data_d[7:0]           = status_vec;
    end

    // Bus response registers and interrupt level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            read_data      <= '0;
            read_response  <= 1'b0;
            write_response <= 1'b0;
            uart_irq       <= 1'b0;
        end else begin
            read_data      <= read_data_d;
            read_response  <= read_request;
            write_response <= write_request;
            uart_irq       <= !rx_empty;
        end
    end

    // Sticky flags: a STATUS read clears them, but a set in the same cycle wins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_overrun   <= 1'b0;
            frame_error  <= 1'b0;
            parity_error <= 1'b0;
            tx_overflow  <= 1'b0;
        end else begin
            rx_overrun   <= (rx_overrun && !rd_st) || (rx_push_vld && rx_full && !rd_rx);
            frame_error  <= (frame_error && !rd_st) || frame_err_set;
            parity_error <= (parity_error && !rd_st) || parity_err_set;
            tx_overflow  <= (tx_overflow && !rd_st) || (wr_tx && tx_full);
        end
    end

    // TX next-state: the line value is registered alongside the state so uart_tx is glitch-free.
    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt + 1'b1;
        tx_idx_d   = tx_idx;
        tx_byte_d  = tx_byte;
        tx_par_d   = tx_par;
        tx_line_d  = tx_line;
        tx_pop_rdy = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_d  = '0;
                tx_line_d = 1'b1;
                if (!tx_empty) begin
                    tx_pop_rdy = 1'b1;
                    tx_byte_d  = tx_head_dat;
                    tx_par_d   = (^tx_head_dat) ^ PAR_ODD;
                    tx_line_d  = 1'b0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_idx_d   = '0;
                    tx_line_d  = tx_byte[0];
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_idx == DATA_LAST) begin
                        tx_idx_d = '0;
                        if (HAS_PARITY) begin
                            tx_line_d  = tx_par;
                            tx_state_d = TX_PARITY;
                        end else begin
                            tx_line_d  = 1'b1;
                            tx_state_d = TX_STOP;
                        end
                    end else begin
                        tx_idx_d  = tx_idx + 1'b1;
                        tx_byte_d = tx_byte >> 1;
                        tx_line_d = tx_byte[1];
                    end
                end
            end
            TX_PARITY: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_idx_d   = '0;
                    tx_line_d  = 1'b1;
                    tx_state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_idx == STOP_LAST) begin
                        // Chain straight into the next frame so there is no idle gap.
                        if (!tx_empty) begin
                            tx_pop_rdy = 1'b1;
                            tx_byte_d  = tx_head_dat;
                            tx_par_d   = (^tx_head_dat) ^ PAR_ODD;
                            tx_line_d  = 1'b0;
                            tx_state_d = TX_START;
                        end else begin
                            tx_line_d  = 1'b1;
                            tx_state_d = TX_IDLE;
                        end
                    end else begin
                        tx_idx_d = tx_idx + 1'b1;
                    end
                end
            end
            default: begin
                tx_line_d  = 1'b1;
                tx_state_d = TX_IDLE;
            end
        endcase
    end

    // TX state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_byte  <= '0;
            tx_par   <= 1'b0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_d;
            tx_cnt   <= tx_cnt_d;
            tx_idx   <= tx_idx_d;
            tx_byte  <= tx_byte_d;
            tx_par   <= tx_par_d;
            tx_line  <= tx_line_d;
        end
    end

    // Two-flop synchroniser for the asynchronous serial input; resets to the idle level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
        end
    end

    // RX next-state: start bit checked at half a bit, later bits every full bit after that.
    always_comb begin
        rx_state_d     = rx_state;
        rx_cnt_d       = rx_cnt + 1'b1;
        rx_idx_d       = rx_idx;
        rx_shift_d     = rx_shift;
        rx_par_bad_d   = rx_par_bad;
        rx_push_vld    = 1'b0;
        frame_err_set  = 1'b0;
        parity_err_set = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (!rx_sync) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_d = '0;
                    if (rx_sync) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_idx_d     = '0;
                        rx_par_bad_d = 1'b0;
                        rx_state_d   = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync, rx_shift[DATA_BITS-1:1]};
                    if (rx_idx == DATA_LAST) rx_state_d = HAS_PARITY ? RX_PARITY : RX_STOP;
                    else                     rx_idx_d   = rx_idx + 1'b1;
                end
            end
            RX_PARITY: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_d = '0;
                    if (rx_sync != ((^rx_shift) ^ PAR_ODD)) begin
                        parity_err_set = 1'b1;
                        rx_par_bad_d   = 1'b1;
                    end
                    rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_d = '0;
                    if (!rx_sync) begin
                        frame_err_set = 1'b1;
                        rx_state_d    = RX_WAIT_HIGH;
                    end else begin
                        rx_push_vld = !rx_par_bad;
                        rx_state_d  = RX_IDLE;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                // A low stop bit may be a break; hold off until the line returns high.
                rx_cnt_d = '0;
                if (rx_sync) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // RX state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_idx     <= '0;
            rx_shift   <= '0;
            rx_par_bad <= 1'b0;
        end else begin
            rx_state   <= rx_state_d;
            rx_cnt     <= rx_cnt_d;
            rx_idx     <= rx_idx_d;
            rx_shift   <= rx_shift_d;
            rx_par_bad <= rx_par_bad_d;
        end
    end
endmodule
